// File: rtl/itch_stream_framer.sv
// Front end for the ITCH decoder bank: accepts multi-byte beats of length-prefixed
// messages and emits one body byte per cycle with start/end framing and statistics.
module itch_stream_framer #(
  parameter int BEAT_BYTES   = 8,
  parameter int MAX_MSG_LEN  = 64,
  parameter int CNT_W        = 32,
  parameter bit DROP_UNKNOWN = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [8*BEAT_BYTES-1:0]          in_data,
  input  logic [$clog2(BEAT_BYTES+1)-1:0]  in_bytes,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [7:0]                       byte_out,
  output logic                             valid_out,
  output logic                             msg_start,
  output logic                             msg_end,
  output logic [7:0]                       msg_type,
  output logic [15:0]                      msg_len,
  output logic                             frame_error,
  output logic [CNT_W-1:0]                 msg_count,
  output logic [CNT_W-1:0]                 drop_count,
  output logic [CNT_W-1:0]                 err_count
);
  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; the
  // source holds in_data/in_bytes/in_valid stable while in_valid && !in_ready.

  localparam int          BW      = $clog2(BEAT_BYTES + 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_LEN);

  typedef enum logic [1:0] {LEN_HI, LEN_LO, TYPE, BODY} state_t;

  state_t                  state_q;
  logic [8*BEAT_BYTES-1:0] beat_q;
  logic [BW-1:0]           bytes_q;
  logic [BW-1:0]           lane_q;
  logic                    full_q;
  logic [15:0]             len_q;
  logic [15:0]             rem_q;
  logic                    keep_q;

  logic [7:0]  cur_byte;
  logic        last_lane;
  logic        accept;
  logic [15:0] len_d;
  logic        supported;
  logic        keep_d;

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (lane_q == BW'(i)) cur_byte = beat_q[i*8 +: 8];
    end
  end

  // The register can refill on the same edge its last lane is consumed.
  assign last_lane = (lane_q == bytes_q - BW'(1));
  assign in_ready  = !full_q || last_lane;
  assign accept    = in_valid && in_ready;
  assign len_d     = {len_q[15:8], cur_byte};

  always_comb begin
    case (cur_byte)
      8'h41, 8'h58, 8'h44, 8'h55, 8'h45,
      8'h50, 8'h46, 8'h42, 8'h43: supported = 1'b1;
      default:                    supported = 1'b0;
    endcase
    keep_d = supported || !DROP_UNKNOWN;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LEN_HI;
      beat_q      <= '0;
      bytes_q     <= '0;
      lane_q      <= '0;
      full_q      <= 1'b0;
      len_q       <= '0;
      rem_q       <= '0;
      keep_q      <= 1'b0;
      byte_out    <= '0;
      valid_out   <= 1'b0;
      msg_start   <= 1'b0;
      msg_end     <= 1'b0;
      msg_type    <= '0;
      msg_len     <= '0;
      frame_error <= 1'b0;
      msg_count   <= '0;
      drop_count  <= '0;
      err_count   <= '0;
    end else begin
      if (accept) begin
        beat_q  <= in_data;
        bytes_q <= in_bytes;
        lane_q  <= '0;
        full_q  <= 1'b1;
      end else if (full_q) begin
        if (last_lane) full_q <= 1'b0;
        else           lane_q <= lane_q + BW'(1);
      end

      valid_out   <= 1'b0;
      msg_start   <= 1'b0;
      msg_end     <= 1'b0;
      frame_error <= 1'b0;

      if (full_q) begin
        case (state_q)
          LEN_HI: begin
            len_q[15:8] <= cur_byte;
            state_q     <= LEN_LO;
          end
          LEN_LO: begin
            if (len_d == 16'd0 || len_d > MAX_LEN) begin
              frame_error <= 1'b1;
              err_count   <= sat_inc(err_count);
              state_q     <= LEN_HI;
            end else begin
              len_q   <= len_d;
              rem_q   <= len_d - 16'd1;
              state_q <= TYPE;
            end
          end
          TYPE: begin
            msg_type  <= cur_byte;
            msg_len   <= len_q;
            keep_q    <= keep_d;
            valid_out <= keep_d;
            msg_start <= keep_d;
            if (keep_d) byte_out <= cur_byte;
            if (!keep_d) drop_count <= sat_inc(drop_count);
            if (len_q == 16'd1) begin
              msg_end <= keep_d;
              if (keep_d) msg_count <= sat_inc(msg_count);
              state_q <= LEN_HI;
            end else begin
              state_q <= BODY;
            end
          end
          BODY: begin
            valid_out <= keep_q;
            if (keep_q) byte_out <= cur_byte;
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              msg_end <= keep_q;
              if (keep_q) msg_count <= sat_inc(msg_count);
              state_q <= LEN_HI;
            end
          end
          default: state_q <= LEN_HI;
        endcase
      end
    end
  end

endmodule

// File: doc/itch_stream_framer.md
Name: itch_stream_framer

Overview:
- Parametrised front end for the speculative ITCH decoder bank.
- Accepts a multi-byte-per-beat stream of length-prefixed ITCH messages (2-byte big-endian length, then the message body) under a valid/ready handshake.
- Strips the length prefix, classifies the message type and filters unsupported types.
- Serialises the retained body bytes to the one-byte-per-cycle decoder interface, adding message start/end framing and statistics counters.

Parameters:
- BEAT_BYTES, 8, bytes per input beat; legal values 1..16.
- MAX_MSG_LEN, 64, largest legal body length in bytes; a body length of 0 or greater than MAX_MSG_LEN is a framing error.
- CNT_W, 32, width of the statistics counters.
- DROP_UNKNOWN, 1, 1 = suppress messages with an unsupported type; 0 = forward every message.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8*BEAT_BYTES  beat data; lane 0 (bits [7:0]) is the earliest byte.
- in_bytes  in  $clog2(BEAT_BYTES+1)  number of valid lanes, 1..BEAT_BYTES, filled from lane 0 upward.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted on an edge where in_valid && in_ready.
- byte_out  out  8  body byte to the decoders.
- valid_out  out  1  byte_out is valid.
- msg_start  out  1  with valid_out: first body byte (the type byte).
- msg_end  out  1  with valid_out: last body byte.
- msg_type  out  8  type of the current message; held until the next type byte.
- msg_len  out  16  body length of the current message; held until the next type byte.
- frame_error  out  1  one-cycle pulse on an illegal length.
- msg_count  out  CNT_W  count of forwarded messages.
- drop_count  out  CNT_W  count of dropped messages.
- err_count  out  CNT_W  count of framing errors.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: all outputs 0 except in_ready = 1. Beat register is empty, FSM is in LEN_HI, all counters are 0.
- Beat buffer: holds one beat plus a lane index. The serialiser consumes exactly one lane per cycle, regardless of FSM state.
- in_ready = beat register empty OR the lane being consumed this cycle is lane in_bytes-1. This allows back-to-back beats with no bubble.
- Latency: a beat accepted at edge t has lane 0 consumed at edge t+1. The corresponding registered outputs are visible from t+1 to t+2. Lane k is consumed at edge t+1+k.
- Upstream must hold in_data, in_bytes and in_valid stable while in_valid && !in_ready.
- FSM (advances once per consumed byte):
  - LEN_HI: len[15:8] <= byte; go to LEN_LO. No valid_out.
  - LEN_LO: len[7:0] <= byte.
    - If len == 0 or len > MAX_MSG_LEN: pulse frame_error, err_count++, return to LEN_HI. The next byte is treated as a new length.
    - Otherwise: remaining <= len-1, go to TYPE.
  - TYPE: the byte is supported if it is one of A,X,D,U,E,P,F,B,C (0x41,0x58,0x44,0x55,0x45,0x50,0x46,0x42,0x43).
    - msg_type and msg_len are updated in all cases.
    - If supported or DROP_UNKNOWN = 0: valid_out = 1, msg_start = 1, keep = 1.
    - Otherwise: keep = 0, drop_count++, no valid_out.
    - If len == 1: msg_end = keep, msg_count++ if keep, go to LEN_HI. Otherwise go to BODY.
  - BODY: valid_out = keep; remaining--. When remaining reaches 0: msg_end = keep, msg_count++ if keep, go to LEN_HI.
- Message framing is independent of beat boundaries. Any field may split across beats.
- Idle cycles (beat register empty) produce valid_out = msg_start = msg_end = 0. The FSM state is held.
- msg_start, msg_end and frame_error are only ever asserted for one cycle per event.
- Counters saturate at all-ones and never wrap.
- rst mid-operation: the partial beat and partial message are discarded and all state returns to reset values. The first byte accepted after reset is parsed as LEN_HI.
- Throughput: at most one body byte per cycle. Each message costs 2 extra cycles for its length prefix.

Test Plan:
1. BEAT_BYTES=8, Delete message (len 0x0013, body starting 0x44) sent as beats of 8,8,5 bytes -> 19 valid_out bytes. msg_start on the first (byte_out=0x44, msg_type=0x44, msg_len=19), msg_end on the 19th, msg_count=1, no frame_error.
2. Back-to-back Cancel (len 23, 'X') then Executed (len 31, 'E') with in_valid held high and the second length split across a beat edge -> exactly 2 idle cycles between the bodies. msg_count=2, in_ready never stalls the source beyond one beat.
3. DROP_UNKNOWN=1: System Event (len 12, 'S') then Replace (len 35, 'U') -> no valid_out for 'S' and drop_count=1. 'U' is forwarded with 35 bytes and msg_count=1. With DROP_UNKNOWN=0 the same stimulus gives msg_count=2, drop_count=0.
4. Length 0x0000, then length 0x1000, then a valid Add (len 36, 'A') -> two single-cycle frame_error pulses and err_count=2. The Add is then parsed correctly from the byte following the bad length.
5. in_bytes=1 on every beat, source deasserting in_valid randomly, Add MPID (len 40, 'F') -> 40 valid_out bytes in order, no duplication or loss, in_ready handshake honoured.
6. rst asserted for one cycle in the 10th body byte of a 'U' message -> next cycle all outputs 0 and counters 0. The following length-prefixed 'D' (len 19) is forwarded intact with msg_count=1.
